// File: rtl/rr_mux.sv
// rr_mux: registered N-input multiplexer with valid/ready handshake, fixed-select
// and round-robin source selection. Define RR_MUX_CNT_EN to add the beat_cnt output.
module rr_mux #(
    parameter int WIDTH = 16,
    parameter int N_IN  = 4,
    parameter int SELW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_f,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SELW-1:0]       out_src
`ifdef RR_MUX_CNT_EN
    ,
    output logic [15:0]           beat_cnt
`endif
);

    logic [SELW-1:0]  rr_ptr_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [SELW-1:0]  out_src_reg;
    logic             out_valid_reg;

    logic [N_IN-1:0]  grant;
    logic             free;
    logic             accept;
    logic [SELW-1:0]  acc_idx;
    logic [WIDTH-1:0] acc_data;

    assign free = !out_valid_reg || out_ready;

    always_comb begin : grant_logic
        logic found;
        grant = '0;
        found = 1'b0;
        if (!mode) begin
            // An out-of-range sel matches no input, so nothing is granted.
            for (int i = 0; i < N_IN; i++) begin
                if (sel == SELW'(i)) begin
                    grant[i] = in_valid[i];
                end
            end
        end else begin
            for (int k = 1; k <= N_IN; k++) begin
                for (int i = 0; i < N_IN; i++) begin
                    if (!found && in_valid[i] && (i == (int'(rr_ptr_reg) + k) % N_IN)) begin
                        grant[i] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
        end
    end

    // Readiness is also held low while reset is asserted.
    assign in_ready = grant & {N_IN{free & rst_f}};
    assign accept   = |in_ready;

    always_comb begin : accept_mux
        acc_idx  = '0;
        acc_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (grant[i]) begin
                acc_idx  = SELW'(i);
                acc_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_src_reg   <= '0;
            rr_ptr_reg    <= SELW'(N_IN - 1);
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= acc_data;
            out_src_reg   <= acc_idx;
            rr_ptr_reg    <= acc_idx;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;

`ifdef RR_MUX_CNT_EN
    logic [15:0] beat_cnt_reg;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            beat_cnt_reg <= '0;
        end else if (out_valid_reg && out_ready) begin
            beat_cnt_reg <= beat_cnt_reg + 16'd1;
        end
    end

    assign beat_cnt = beat_cnt_reg;
`else
    // Build without the consumed-beat counter.
`endif

endmodule

// File: tb/tb_rr_mux.sv
// Self-checking bench for rr_mux: directed steps plus randomized traffic checked
// against a behavioural model of the selection and output-register rules.
module tb_rr_mux;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst_f;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_src;

    logic [2:0]     in_ready3;
    logic [W-1:0]   out_data3;
    logic           out_valid3;
    logic [SW-1:0]  out_src3;
`ifdef RR_MUX_CNT_EN
    logic [15:0]    beat_cnt;
    logic [15:0]    beat_cnt3;
`endif

    rr_mux #(.WIDTH(W), .N_IN(N), .SELW(SW)) u_dut (
        .clk       (clk),
        .rst_f     (rst_f),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src)
`ifdef RR_MUX_CNT_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    // Three-input instance to exercise an out-of-range fixed select.
    rr_mux #(.WIDTH(W), .N_IN(3), .SELW(SW)) u_dut3 (
        .clk       (clk),
        .rst_f     (rst_f),
        .in_data   (in_data[3*W-1:0]),
        .in_valid  (in_valid[2:0]),
        .in_ready  (in_ready3),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .out_src   (out_src3)
`ifdef RR_MUX_CNT_EN
        ,
        .beat_cnt  (beat_cnt3)
`endif
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;
    int fails  = 0;

    // Reference model state
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_src;
    int           m_ptr;
    int           m_cnt;
    logic [W-1:0] consumed[$];
    bit           auto_gen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_ptr   = N - 1;
        m_cnt   = 0;
    endtask

    task automatic set_data(input int i, input logic [W-1:0] v);
        in_data[i*W +: W] = v;
    endtask

    function automatic logic [N-1:0] exp_ready();
        int cand;
        int j;
        logic [N-1:0] r;
        cand = -1;
        r    = '0;
        if (rst_f !== 1'b1) return r;
        if (mode == 1'b0) begin
            if (int'(sel) < N) cand = int'(sel);
        end else begin
            for (int k = 1; k <= N; k++) begin
                j = (m_ptr + k) % N;
                if (in_valid[j]) begin
                    cand = j;
                    break;
                end
            end
        end
        if (cand >= 0 && in_valid[cand] && (!m_valid || out_ready)) r[cand] = 1'b1;
        return r;
    endfunction

    // One clock: check at the falling edge, advance the model, optionally refresh upstream.
    task automatic cycle();
        logic [N-1:0] er;
        er = exp_ready();
        @(negedge clk);
        er = exp_ready();
        check("in_ready", in_ready, er);
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("out_src", out_src, m_src);
`ifdef RR_MUX_CNT_EN
        check("beat_cnt", beat_cnt, m_cnt % 65536);
`endif
        if (rst_f !== 1'b1) begin
            model_reset();
        end else begin
            if (m_valid && out_ready) begin
                consumed.push_back(m_data);
                m_cnt++;
            end
            if (er != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (er[i]) begin
                        m_data = in_data[i*W +: W];
                        m_src  = i;
                        m_ptr  = i;
                    end
                end
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        if (auto_gen) begin
            for (int i = 0; i < N; i++) begin
                if (er[i] || !in_valid[i]) begin
                    in_valid[i] = 1'($urandom_range(0, 1));
                    set_data(i, W'($urandom));
                end
            end
            mode      = 1'($urandom_range(0, 1));
            sel       = SW'($urandom_range(0, N - 1));
            out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    logic [W-1:0] fair_exp [5];
    int           skip_exp [4];

    initial begin
        fair_exp = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1000};
        skip_exp = '{3, 1, 3, 1};
        auto_gen  = 1'b0;
        model_reset();

        // Reset held with random inputs
        rst_f     = 1'b0;
        in_data   = {$urandom, $urandom};
        in_valid  = N'($urandom_range(1, 15));
        mode      = 1'($urandom_range(0, 1));
        sel       = SW'($urandom_range(0, 3));
        out_ready = 1'b1;
        cycle();
        cycle();
        #1 rst_f = 1'b1;

        // Fixed mode, sel=2
        mode      = 1'b0;
        sel       = 2'd2;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_data(i, W'(16'h0100 + i));
        set_data(2, 16'hBEEF);
        cycle();
        check("fixed_out_data", out_data, 16'hBEEF);
        check("fixed_out_src", out_src, 2);
        check("dut3_out_data", out_data3, 16'hBEEF);

        // sel beyond the three-input instance
        sel = 2'd3;
        #1 check("dut3_in_ready_oob", in_ready3, 3'b000);
        cycle();
        check("dut3_out_valid_oob", out_valid3, 1'b0);
        check("fixed_sel3_src", out_src, 3);

        // Asynchronous reset while a beat is held
        #2 rst_f = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_data", out_data, 16'h0000);
        check("async_rst_in_ready", in_ready, 4'b0000);
        model_reset();
        @(posedge clk);
        #1 rst_f = 1'b1;

        // Round-robin fairness
        mode = 1'b1;
        for (int i = 0; i < N; i++) set_data(i, W'(16'h1000 + i));
        consumed.delete();
        repeat (6) cycle();
        check("fair_count", consumed.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fair_beat%0d", i), (i < consumed.size()) ? consumed[i] : 16'hDEAD, fair_exp[i]);
        end

        // Round-robin skip, then a single requester
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check($sformatf("skip_src%0d", i), out_src, skip_exp[i]);
        end
        in_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("single_src%0d", i), out_src, 1);
            check($sformatf("single_valid%0d", i), out_valid, 1'b1);
        end

        // Back-pressure
        mode     = 1'b0;
        sel      = 2'd0;
        in_valid = 4'b0001;
        set_data(0, 16'h00AA);
        cycle();
        check("bp_loaded", out_data, 16'h00AA);
        set_data(0, 16'h00BB);
        out_ready = 1'b0;
        repeat (3) cycle();
        check("bp_hold_data", out_data, 16'h00AA);
        check("bp_in_ready", in_ready, 4'b0000);
        check("bp_upstream_valid", in_valid, 4'b0001);
        out_ready = 1'b1;
        consumed.delete();
        cycle();
        check("bp_consumed", (consumed.size() > 0) ? consumed[consumed.size()-1] : 16'hDEAD, 16'h00AA);
        check("bp_next_loaded", out_data, 16'h00BB);
        check("bp_valid_kept", out_valid, 1'b1);

        // Randomized traffic
        auto_gen = 1'b1;
        repeat (400) cycle();
        auto_gen = 1'b0;

`ifdef RR_MUX_CNT_EN
        // Beat counter: five consumes, then wrap after 65536
        #2 rst_f = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_f = 1'b1;
        mode      = 1'b0;
        sel       = 2'd0;
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        repeat (6) cycle();
        check("cnt_five", beat_cnt, 16'd5);
        repeat (65531) @(posedge clk);
        #1 check("cnt_wrap", beat_cnt, 16'd0);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
